ypb_mem_responder: RTL and testbench
====================================

# ypb_mem_responder

Single-port YPB target that answers one pipeline request channel (fetch, load, store, AMO, PTW or Zcmt) from an internal word-addressed memory. It decodes each granted request, writes or reads the array, and returns the response after a fixed, parameterised latency with the request's transaction ID echoed. It sits at the memory end of the YPB interface, in place of the cache or OBI adapter subsystem, for pipeline-only test harnesses and small tightly-coupled memories.

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; supplies `PLEN` and the ID width.
- `ypb_req_t`, `logic`: YPB request struct for the attached channel.
- `ypb_rsp_t`, `logic`: YPB response struct for the attached channel.
- `DataWidth`, 64: `wdata`/`rdata` width; `CVA6Cfg.XLEN` or `CVA6Cfg.FETCH_WIDTH`.
- `NumWords`, 1024: array depth in `DataWidth` words; power of two.
- `Latency`, 2: cycles from grant to `rvalid`; legal range 1..8.
- `BaseAddr`, 0: physical byte address of word 0; aligned to `NumWords*DataWidth/8`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; asynchronous, active-high.
- `stall_i`, in, 1: when high, forces `ypb_rsp_o.gnt` low (back-pressure injection).
- `ypb_req_i`, in, `ypb_req_t`: request fields used are `req`, `paddr`, `we`, `be`, `wdata`, `aid`.
- `ypb_rsp_o`, out, `ypb_rsp_t`: response fields driven are `gnt`, `rvalid`, `rdata`, `rid`, `err`.
  - All other fields are driven to 0.

## Operation
**Grant.** `gnt = req & ~stall_i`, combinational. Acceptance = `req & gnt`.

**Decode** (in the acceptance cycle):
- Word index = `(paddr - BaseAddr) >> log2(DataWidth/8)`.
- Out of range when `paddr < BaseAddr`, or when the index is ≥ `NumWords`.
- Offset width is `PLEN`; the subtraction must not wrap into range.

**Write** (`we`=1, in range):
- Bytes with `be[i]`=1 are updated at the clock edge that ends the acceptance cycle.
- Bytes with `be[i]`=0 are unchanged.
- `be`=0 is a legal no-op write that still produces a response.

**Read** (`we`=0, in range): the array word is sampled at acceptance.
- A write accepted in an earlier cycle is always visible to the read.
- Only one request is accepted per cycle, so a read and a write never occur in the same cycle.

**Error** (out of range):
- No array access.
- The response has `err`=1 and `rdata`=0.
- For writes, the array is untouched.

**Response pipeline.** A `Latency`-stage shift register carries `{valid, aid, rdata, err}`.
- Stage 0 is loaded at acceptance. Each stage advances every cycle, unconditionally.
- Responses cannot be back-pressured. The initiator must accept `rvalid` whenever it is presented.
- Write responses carry `rdata`=0.
- Responses are strictly in order, one per accepted request, with `rid` = the accepted `aid`.

**No state machine beyond the pipeline.** Throughput is one request per cycle. Up to `Latency` requests are in flight.

**Reset:**
- All pipeline valid bits clear, so `rvalid`=0, `rdata`=0, `rid`=0, `err`=0. `gnt` follows its combinational definition.
- Array contents are not reset and are undefined until written.
- Reset mid-operation discards every in-flight response; no response is issued for them after reset release.

## Timing
- Request accepted at edge N ⇒ `rvalid` high during cycle N+`Latency`, for exactly one cycle.
- Back-to-back accepts in cycles N and N+1 ⇒ `rvalid` in N+`Latency` and N+`Latency`+1, in the same order.
- `stall_i` affects only `gnt`. In-flight responses continue while stalled.
- `req` held high while `gnt`=0: nothing is accepted and there is no side effect.
- The request must be held stable until granted (YPB rule; not checked).
- Rise of `rst_i` clears outputs asynchronously. The first accept is possible in the first cycle after deassertion.

## Structure
- Stage record type `ypb_resp_stage_t {valid, aid, rdata, err}` and the legality checks for `Latency` and `NumWords` belong in a shared package. Place them beside the YPB macros in `ypb_types.svh` / `ariane_pkg`.
- One sub-module: `ypb_mem_array`.
  - Byte-enabled, single-port, synchronous-write / combinational-read array of `NumWords` × `DataWidth`.
  - Replaceable by an SRAM macro wrapper.
- Top level holds decode, grant and the response shift register.
- Elaboration-time asserts reject `Latency`=0 and a non-power-of-two `NumWords`.

## Test plan
- **Reset:** assert `rst_i` mid-cycle with 2 reads in flight (`Latency`=2).
  - Outputs go to 0 immediately.
  - No `rvalid` appears after release.
- **Write then read:** write 0xDEADBEEF_CAFEF00D to `BaseAddr`+8 with `be`=0xFF and `aid`=1, then read it with `aid`=2.
  - `rvalid` for `rid`=1 then `rid`=2, `Latency` cycles after each accept.
  - The read returns 0xDEADBEEF_CAFEF00D.
- **Partial write:** write 0x11223344_55667788 with `be`=0x0F over the above, then read.
  - Read returns 0xDEADBEEF_55667788.
- **Back-to-back stream:** 8 reads in 8 consecutive cycles with `aid` 0..7.
  - 8 consecutive `rvalid` cycles, `rid` in order 0..7, each with correct data.
- **Stall:** `stall_i` high for 3 cycles with `req` high.
  - `gnt`=0 for 3 cycles, no new responses; in-flight responses still complete.
  - Accept occurs on the first cycle after `stall_i` falls.
- **Out of range:** read at `BaseAddr`−8 and at `BaseAddr`+`NumWords`*8; write at `BaseAddr`+`NumWords`*8.
  - Each response has `err`=1 and `rdata`=0.
  - A subsequent read of word `NumWords`−1 is unchanged.

Source files
------------

// File: rtl/ypb_mem_responder_pkg.sv
// Shared types and elaboration checks for the YPB memory responder.
// Request/response structs model one YPB pipeline channel of a 64-bit core.
package ypb_mem_responder_pkg;

    localparam int unsigned PLEN  = 56;
    localparam int unsigned AID_W = 4;
    localparam int unsigned XLEN  = 64;

    typedef struct packed {
        logic              req;
        logic [PLEN-1:0]   paddr;
        logic              we;
        logic [XLEN/8-1:0] be;
        logic [XLEN-1:0]   wdata;
        logic [AID_W-1:0]  aid;
    } ypb_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [XLEN-1:0]   rdata;
        logic [AID_W-1:0]  rid;
        logic              err;
        logic [3:0]        ruser;
    } ypb_rsp_t;

    typedef struct packed {
        logic              valid;
        logic [AID_W-1:0]  aid;
        logic [XLEN-1:0]   rdata;
        logic              err;
    } ypb_resp_stage_t;

    function automatic bit latency_legal(input int unsigned lat);
        return (lat >= 1) && (lat <= 8);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ypb_mem_array.sv
// Byte-enabled single-port storage: synchronous write, combinational read.
// Kept minimal so an SRAM macro wrapper can drop in with the same ports.
module ypb_mem_array #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned AddrW     = $clog2(NumWords)
) (
    input  logic                   i_clk,
    input  logic                   i_we,
    input  logic [DataWidth/8-1:0] i_be,
    input  logic [AddrW-1:0]       i_addr,
    input  logic [DataWidth-1:0]   i_wdata,
    output logic [DataWidth-1:0]   o_rdata
);

    logic [DataWidth-1:0] r_mem [NumWords];

    // Contents are deliberately not reset; they are undefined until written.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < DataWidth / 8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ypb_mem_responder.sv
// YPB target answering one pipeline channel from a local word array,
// returning in-order responses after a fixed Latency-cycle pipeline.
module ypb_mem_responder
    import ypb_mem_responder_pkg::*;
#(
    parameter int unsigned     DataWidth = XLEN,
    parameter int unsigned     NumWords  = 1024,
    parameter int unsigned     Latency   = 2,
    parameter logic [PLEN-1:0] BaseAddr  = '0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     stall_i,
    input  ypb_req_t ypb_req_i,
    output ypb_rsp_t ypb_rsp_o
);

    localparam int unsigned OffW  = $clog2(DataWidth / 8);
    localparam int unsigned AddrW = $clog2(NumWords);

    if (!latency_legal(Latency)) begin : g_badLatency
        $fatal(1, "ypb_mem_responder: Latency must be in 1..8");
    end
    if (!is_pow2(NumWords)) begin : g_badNumWords
        $fatal(1, "ypb_mem_responder: NumWords must be a power of two");
    end
    if (DataWidth != XLEN) begin : g_badDataWidth
        $fatal(1, "ypb_mem_responder: DataWidth must match the channel width");
    end

    logic                 w_gnt;
    logic                 w_accept;
    logic                 w_below;
    logic                 w_inRange;
    logic [PLEN-1:0]      w_offset;
    logic [AddrW-1:0]     w_wordAddr;
    logic [DataWidth-1:0] w_rdata;
    logic                 w_unused;
    ypb_resp_stage_t      w_stage;
    ypb_resp_stage_t      r_pipe [Latency];

    assign w_gnt    = ypb_req_i.req & ~stall_i;
    assign w_accept = ypb_req_i.req & w_gnt;

    // The below-base test guards against the subtraction wrapping into range.
    assign w_below    = ypb_req_i.paddr < BaseAddr;
    assign w_offset   = ypb_req_i.paddr - BaseAddr;
    assign w_inRange  = !w_below && (w_offset[PLEN-1:OffW+AddrW] == '0);
    assign w_wordAddr = w_offset[OffW +: AddrW];
    assign w_unused   = ^w_offset[OffW-1:0];

    ypb_mem_array #(
        .DataWidth (DataWidth),
        .NumWords  (NumWords)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_accept & ypb_req_i.we & w_inRange),
        .i_be    (ypb_req_i.be),
        .i_addr  (w_wordAddr),
        .i_wdata (ypb_req_i.wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_stage = '0;
        if (w_accept) begin
            w_stage.valid = 1'b1;
            w_stage.aid   = ypb_req_i.aid;
            w_stage.err   = !w_inRange;
            if (w_inRange && !ypb_req_i.we) begin
                w_stage.rdata = w_rdata;
            end
        end
    end

    // Free-running shift register: responses cannot be back-pressured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_stage;
            for (int i = 1; i < Latency; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_comb begin
        ypb_rsp_o        = '0;
        ypb_rsp_o.gnt    = w_gnt;
        ypb_rsp_o.rvalid = r_pipe[Latency-1].valid;
        ypb_rsp_o.rdata  = r_pipe[Latency-1].rdata;
        ypb_rsp_o.rid    = r_pipe[Latency-1].aid;
        ypb_rsp_o.err    = r_pipe[Latency-1].err;
    end

endmodule

// File: tb/tb_ypb_mem_responder.sv
// Directed bench for ypb_mem_responder with a reference memory model and
// an in-order response scoreboard checked on the falling clock edge.
module tb_ypb_mem_responder;
    import ypb_mem_responder_pkg::*;

    localparam int unsigned LAT  = 2;
    localparam int unsigned NW   = 64;
    localparam logic [55:0] BASE = 56'h0000_8000_0000;

    typedef struct {
        logic [3:0]  aid;
        logic [63:0] data;
        logic        err;
        int          cycle;
    } expect_t;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     stall = 1'b0;
    ypb_req_t req = '0;
    ypb_rsp_t rsp;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    expect_t     sb[$];
    logic [63:0] model [int];

    ypb_mem_responder #(
        .DataWidth (64),
        .NumWords  (NW),
        .Latency   (LAT),
        .BaseAddr  (BASE)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .stall_i   (stall),
        .ypb_req_i (req),
        .ypb_rsp_o (rsp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request, holding stall for stallCycles before it may be granted.
    task automatic applyStimulus(input logic we, input logic [55:0] addr, input logic [7:0] be,
                                 input logic [63:0] wdata, input logic [3:0] aid, input int stallCycles);
        expect_t     e;
        bit          inRange;
        int          idx;
        logic [63:0] old;
        req.req   = 1'b1;
        req.we    = we;
        req.paddr = addr;
        req.be    = be;
        req.wdata = wdata;
        req.aid   = aid;
        for (int c = 0; c <= stallCycles; c++) begin
            stall = (c < stallCycles);
            @(negedge clk);
            checkOutput("gnt", 64'(rsp.gnt), 64'(c == stallCycles));
            if (rsp.gnt) begin
                inRange = (addr >= BASE) && ((addr - BASE) < 56'(NW * 8));
                idx     = int'((addr - BASE) >> 3);
                e.aid   = aid;
                e.err   = !inRange;
                e.data  = '0;
                e.cycle = cyc + LAT;
                if (inRange && we) begin
                    old = model.exists(idx) ? model[idx] : 64'h0;
                    for (int b = 0; b < 8; b++) begin
                        if (be[b]) old[b*8 +: 8] = wdata[b*8 +: 8];
                    end
                    model[idx] = old;
                end else if (inRange) begin
                    e.data = model.exists(idx) ? model[idx] : 64'hx;
                end
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        req.req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Response monitor: every rvalid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expect_t e;
        if (!rst && rsp.rvalid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rvalid", 64'(rsp.rid), 64'hffff);
            end else begin
                e = sb.pop_front();
                checkOutput("rid", 64'(rsp.rid), 64'(e.aid));
                checkOutput("rdata", rsp.rdata, e.data);
                checkOutput("err", 64'(rsp.err), 64'(e.err));
                checkOutput("latency", 64'(cyc), 64'(e.cycle));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("reset_rvalid", 64'(rsp.rvalid), 64'h0);
        checkOutput("reset_rid", 64'(rsp.rid), 64'h0);
        checkOutput("reset_rdata", rsp.rdata, 64'h0);
        checkOutput("reset_err", 64'(rsp.err), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write then read
        applyStimulus(1'b1, BASE + 56'd8, 8'hFF, 64'hDEADBEEF_CAFEF00D, 4'd1, 0);
        applyStimulus(1'b0, BASE + 56'd8, 8'h00, 64'h0, 4'd2, 0);
        idleCycles(3);
        checkOutput("wr_rd_value", model[1], 64'hDEADBEEF_CAFEF00D);

        // Partial write, then a be=0 no-op write, then read
        applyStimulus(1'b1, BASE + 56'd8, 8'h0F, 64'h11223344_55667788, 4'd3, 0);
        applyStimulus(1'b1, BASE + 56'd8, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 4'd4, 0);
        applyStimulus(1'b0, BASE + 56'd8, 8'h00, 64'h0, 4'd5, 0);
        idleCycles(3);
        checkOutput("partial_value", model[1], 64'hDEADBEEF_55667788);

        // Preload words 0..7 and the last word
        for (int i = 0; i < 8; i++) begin
            if (i != 1) applyStimulus(1'b1, BASE + 56'(i * 8), 8'hFF, {32'hA5A5_0000 + 32'(i), $urandom}, 4'(i), 0);
        end
        applyStimulus(1'b1, BASE + 56'((NW - 1) * 8), 8'hFF, 64'h0123_4567_89AB_CDEF, 4'd9, 0);
        idleCycles(3);

        // Back-to-back stream of 8 reads
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, BASE + 56'(i * 8), 8'h00, 64'h0, 4'(i), 0);
        end
        idleCycles(3);

        // Stall with a read in flight; accept on the cycle stall falls
        applyStimulus(1'b0, BASE + 56'd16, 8'h00, 64'h0, 4'd10, 0);
        applyStimulus(1'b0, BASE + 56'd24, 8'h00, 64'h0, 4'd11, 3);
        idleCycles(3);

        // Out of range: below base, just past the end, and a write past the end
        applyStimulus(1'b0, BASE - 56'd8, 8'h00, 64'h0, 4'd12, 0);
        applyStimulus(1'b0, BASE + 56'(NW * 8), 8'h00, 64'h0, 4'd13, 0);
        applyStimulus(1'b1, BASE + 56'(NW * 8), 8'hFF, 64'hBAD0_BAD0_BAD0_BAD0, 4'd14, 0);
        applyStimulus(1'b0, BASE + 56'((NW - 1) * 8), 8'h00, 64'h0, 4'd15, 0);
        applyStimulus(1'b0, BASE, 8'h00, 64'h0, 4'd0, 0);
        idleCycles(3);

        // Reset mid-operation with two reads in flight
        applyStimulus(1'b0, BASE + 56'd8, 8'h00, 64'h0, 4'd6, 0);
        applyStimulus(1'b0, BASE + 56'd32, 8'h00, 64'h0, 4'd7, 0);
        req.req = 1'b0;
        #1;
        checkOutput("pre_reset_rvalid", 64'(rsp.rvalid), 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("async_rvalid", 64'(rsp.rvalid), 64'h0);
        checkOutput("async_rid", 64'(rsp.rid), 64'h0);
        checkOutput("async_rdata", rsp.rdata, 64'h0);
        checkOutput("async_err", 64'(rsp.err), 64'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idleCycles(5);

        // A final read after reset still works
        applyStimulus(1'b0, BASE + 56'd8, 8'h00, 64'h0, 4'd8, 0);
        req.req = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
